// File: rtl/from_emulator.sv
// 128-byte emulator image store: self-fills on reset, reloads from a byte
// stream on request, and serves one-cycle-latency reads throughout.
module from_emulator #(
  parameter int unsigned INIT_MODE = 1
) (
  input  logic       from_clk,
  input  logic       reset,
  input  logic [6:0] from_addr,
  output logic [7:0] from_data,
  input  logic       prog_start,
  input  logic       prog_abort,
  input  logic       prog_valid,
  input  logic [7:0] prog_data,
  output logic       prog_ready,
  output logic       prog_busy,
  output logic       prog_done,
  output logic [7:0] checksum
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LOAD} state_e;

  state_e     state_q;
  logic [6:0] wptr_q;
  logic [7:0] sum_q;
  logic [7:0] checksum_q;
  logic       done_q;
  logic [7:0] from_data_q;
  logic [7:0] mem [128];

  logic       accept;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] sum_d;

  always_comb begin
    accept    = (state_q == ST_LOAD) && prog_valid;
    mem_we    = !reset && ((state_q == ST_INIT) || accept);
    mem_wdata = prog_data;
    if (state_q == ST_INIT) begin
      mem_wdata = (INIT_MODE == 0) ? 8'h00 : {1'b0, wptr_q};
    end
    sum_d = sum_q + mem_wdata;
  end

  // NOTE: the array has no reset; INIT rewrites every entry after reset, and
  // a resettable array would not map onto a RAM macro.
  always_ff @(posedge from_clk) begin
    if (mem_we) begin
      mem[wptr_q] <= mem_wdata;
    end
  end

  // NOTE: non-blocking assignments make a same-cycle read of the address
  // being written return the old byte (read-first).
  always_ff @(posedge from_clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      wptr_q      <= 7'd0;
      sum_q       <= 8'h00;
      checksum_q  <= 8'h00;
      done_q      <= 1'b0;
      from_data_q <= 8'h00;
    end else begin
      done_q      <= 1'b0;
      from_data_q <= (state_q == ST_INIT) ? 8'h00 : mem[from_addr];
      case (state_q)
        ST_INIT: begin
          wptr_q <= wptr_q + 7'd1;
          sum_q  <= sum_d;
          if (wptr_q == 7'd127) begin
            state_q    <= ST_IDLE;
            checksum_q <= sum_d;
          end
        end
        ST_IDLE: begin
          if (prog_start) begin
            state_q <= ST_LOAD;
            wptr_q  <= 7'd0;
            sum_q   <= 8'h00;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wptr_q <= wptr_q + 7'd1;
            sum_q  <= sum_d;
            if (wptr_q == 7'd127) begin
              state_q <= ST_IDLE;
              // An abort in the same cycle still writes the byte but
              // suppresses completion.
              if (!prog_abort) begin
                done_q     <= 1'b1;
                checksum_q <= sum_d;
              end
            end
          end
          if (prog_abort) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign from_data  = from_data_q;
  assign prog_ready = (state_q == ST_LOAD);
  assign prog_busy  = (state_q != ST_IDLE);
  assign prog_done  = done_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_from_emulator.sv
// Directed bench for from_emulator: fill, reads, reloads, abort and reset cases.
module tb_from_emulator;

  logic       from_clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] from_addr = 7'd0;
  logic [7:0] from_data;
  logic       prog_start = 1'b0;
  logic       prog_abort = 1'b0;
  logic       prog_valid = 1'b0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_ready;
  logic       prog_busy;
  logic       prog_done;
  logic [7:0] checksum;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  from_emulator #(.INIT_MODE(1)) dut (
    .from_clk  (from_clk),
    .reset     (reset),
    .from_addr (from_addr),
    .from_data (from_data),
    .prog_start(prog_start),
    .prog_abort(prog_abort),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_ready(prog_ready),
    .prog_busy (prog_busy),
    .prog_done (prog_done),
    .checksum  (checksum)
  );

  always #5 from_clk = ~from_clk;

  // Counts every cycle in which prog_done was high.
  always @(posedge from_clk) if (prog_done === 1'b1) done_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge from_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; prog_start = 1'b0; prog_abort = 1'b0; prog_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_load();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  // Runs until prog_busy drops (bounded), optionally pulsing prog_start at cycle start_at.
  task automatic wait_init(input int start_at, output int cycles, output int nonzero);
    cycles = 0;
    nonzero = 0;
    while (cycles < 300) begin
      prog_start = (cycles + 1 == start_at);
      tick();
      cycles++;
      if (from_data !== 8'h00) nonzero++;
      if (prog_busy === 1'b0) break;
    end
    prog_start = 1'b0;
  endtask

  task automatic read_expect(input logic [6:0] addr, input logic [7:0] exp, input string name);
    from_addr = addr;
    tick();
    n_cmp++;
    if (from_data !== exp) begin
      n_err++;
      $display("FAIL %s addr=%0d: got 0x%02h want 0x%02h", name, addr, from_data, exp);
    end
  endtask

  task automatic test_reset();
    int cycles, nonzero;
    from_addr = 7'd5;
    do_reset();
    n_cmp++; if (from_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got 0x%02h want 0x00", from_data); end
    n_cmp++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", prog_done); end
    n_cmp++; if (checksum !== 8'h00) begin n_err++; $display("FAIL reset_checksum: got 0x%02h want 0x00", checksum); end
    n_cmp++; if (prog_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", prog_busy); end
    n_cmp++; if (prog_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", prog_ready); end
    wait_init(0, cycles, nonzero);
    n_cmp++; if (cycles != 128) begin n_err++; $display("FAIL init_length: got %0d want 128", cycles); end
    n_cmp++; if (nonzero != 0) begin n_err++; $display("FAIL init_read_zero: got %0d nonzero reads want 0", nonzero); end
    n_cmp++; if (checksum !== 8'hC0) begin n_err++; $display("FAIL init_checksum: got 0x%02h want 0xc0", checksum); end
    n_cmp++; if (prog_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", prog_ready); end
  endtask

  task automatic test_read_sweep();
    for (int a = 0; a < 128; a++) begin
      logic [7:0] exp;
      exp = 8'(a);
      read_expect(exp[6:0], exp, "sweep");
    end
  endtask

  task automatic test_full_load();
    int base = done_seen;
    int early = 0;
    start_load();
    n_cmp++; if (prog_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b want 1", prog_ready); end
    n_cmp++; if (prog_busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b want 1", prog_busy); end
    prog_valid = 1'b1;
    prog_data  = 8'hFF;
    for (int i = 1; i <= 128; i++) begin
      tick();
      if (i < 128 && prog_done !== 1'b0) early++;
    end
    n_cmp++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", prog_done); end
    n_cmp++; if (prog_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low: got %b want 0", prog_ready); end
    n_cmp++; if (prog_busy !== 1'b0) begin n_err++; $display("FAIL full_busy: got %b want 0", prog_busy); end
    n_cmp++; if (checksum !== 8'h80) begin n_err++; $display("FAIL full_checksum: got 0x%02h want 0x80", checksum); end
    n_cmp++; if (early != 0) begin n_err++; $display("FAIL full_early_done: got %0d want 0", early); end
    prog_valid = 1'b0;
    tick();
    n_cmp++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL full_done_pulse: got %b want 0", prog_done); end
    read_expect(7'd0, 8'hFF, "full_read");
    read_expect(7'd64, 8'hFF, "full_read");
    read_expect(7'd127, 8'hFF, "full_read");
    n_cmp++; if (done_seen - base != 1) begin n_err++; $display("FAIL full_done_count: got %0d want 1", done_seen - base); end
  endtask

  task automatic test_toggle_valid();
    int acc = 0;
    int c = 0;
    int stalls_bad = 0;
    logic [7:0] exp_sum = 8'h00;
    start_load();
    while (acc < 128 && c < 400) begin
      if (c % 2 == 0) begin
        prog_valid = 1'b1;
        prog_data  = 8'(acc * 5 + 7);
      end else begin
        prog_valid = 1'b0;
        prog_data  = 8'hEE;
      end
      tick();
      if (prog_valid) begin
        exp_sum = exp_sum + prog_data;
        acc++;
      end else if (prog_ready !== 1'b1 || prog_done !== 1'b0) begin
        stalls_bad++;
      end
      c++;
    end
    n_cmp++; if (acc != 128) begin n_err++; $display("FAIL toggle_accepts: got %0d want 128", acc); end
    n_cmp++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL toggle_done: got %b want 1", prog_done); end
    n_cmp++; if (stalls_bad != 0) begin n_err++; $display("FAIL toggle_stall_state: got %0d bad want 0", stalls_bad); end
    n_cmp++; if (checksum !== exp_sum) begin n_err++; $display("FAIL toggle_checksum: got 0x%02h want 0x%02h", checksum, exp_sum); end
    prog_valid = 1'b0;
    read_expect(7'd0, 8'd7, "toggle_read");
    read_expect(7'd1, 8'd12, "toggle_read");
    read_expect(7'd50, 8'(50 * 5 + 7), "toggle_read");
    read_expect(7'd127, 8'(127 * 5 + 7), "toggle_read");
  endtask

  task automatic test_abort();
    int cycles, nonzero, base;
    do_reset();
    wait_init(0, cycles, nonzero);
    base = done_seen;
    start_load();
    prog_valid = 1'b1;
    prog_data  = 8'h55;
    repeat (10) tick();
    prog_valid = 1'b0;
    prog_abort = 1'b1;
    tick();
    prog_abort = 1'b0;
    n_cmp++; if (prog_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", prog_busy); end
    n_cmp++; if (checksum !== 8'hC0) begin n_err++; $display("FAIL abort_checksum: got 0x%02h want 0xc0", checksum); end
    for (int a = 0; a < 10; a++) begin
      logic [7:0] av;
      av = 8'(a);
      read_expect(av[6:0], 8'h55, "abort_read");
    end
    read_expect(7'd10, 8'h0A, "abort_untouched");
    n_cmp++; if (done_seen != base) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen - base); end
  endtask

  task automatic test_abort_last();
    int base = done_seen;
    start_load();
    prog_valid = 1'b1;
    prog_data  = 8'h11;
    repeat (127) tick();
    prog_data  = 8'h22;
    prog_abort = 1'b1;
    tick();
    prog_valid = 1'b0;
    prog_abort = 1'b0;
    n_cmp++; if (prog_busy !== 1'b0) begin n_err++; $display("FAIL abort_last_busy: got %b want 0", prog_busy); end
    n_cmp++; if (checksum !== 8'hC0) begin n_err++; $display("FAIL abort_last_checksum: got 0x%02h want 0xc0", checksum); end
    read_expect(7'd127, 8'h22, "abort_last_read");
    read_expect(7'd126, 8'h11, "abort_last_read");
    n_cmp++; if (done_seen != base) begin n_err++; $display("FAIL abort_last_no_done: got %0d pulses want 0", done_seen - base); end
  endtask

  task automatic test_start_in_load();
    start_load();
    prog_valid = 1'b1;
    prog_data = 8'h01; tick();
    prog_data = 8'h02; tick();
    prog_data = 8'h03; prog_start = 1'b1; tick();
    prog_start = 1'b0;
    prog_data = 8'h04; tick();
    prog_valid = 1'b0;
    prog_abort = 1'b1; tick();
    prog_abort = 1'b0;
    read_expect(7'd0, 8'h01, "start_in_load");
    read_expect(7'd2, 8'h03, "start_in_load");
    read_expect(7'd3, 8'h04, "start_in_load");
  endtask

  task automatic test_reset_during_load();
    int cycles, nonzero;
    int base = done_seen;
    start_load();
    prog_valid = 1'b1;
    prog_data  = 8'h77;
    repeat (50) tick();
    prog_valid = 1'b0;
    from_addr  = 7'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (checksum !== 8'h00) begin n_err++; $display("FAIL rst_load_checksum_clr: got 0x%02h want 0x00", checksum); end
    wait_init(20, cycles, nonzero);
    n_cmp++; if (cycles != 128) begin n_err++; $display("FAIL rst_load_init_length: got %0d want 128", cycles); end
    n_cmp++; if (nonzero != 0) begin n_err++; $display("FAIL rst_load_read_zero: got %0d nonzero want 0", nonzero); end
    n_cmp++; if (checksum !== 8'hC0) begin n_err++; $display("FAIL rst_load_checksum: got 0x%02h want 0xc0", checksum); end
    n_cmp++; if (prog_ready !== 1'b0) begin n_err++; $display("FAIL rst_load_ready: got %b want 0", prog_ready); end
    read_expect(7'd3, 8'h03, "rst_load_read");
    read_expect(7'd49, 8'h31, "rst_load_read");
    read_expect(7'd0, 8'h00, "rst_load_read");
    n_cmp++; if (done_seen != base) begin n_err++; $display("FAIL rst_load_no_done: got %0d pulses want 0", done_seen - base); end
  endtask

  task automatic test_read_first();
    start_load();
    prog_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      prog_data = 8'(k);
      tick();
    end
    from_addr = 7'd5;
    prog_data = 8'hAA;
    tick();
    n_cmp++; if (from_data !== 8'h05) begin n_err++; $display("FAIL read_first_old: got 0x%02h want 0x05", from_data); end
    prog_valid = 1'b0;
    tick();
    n_cmp++; if (from_data !== 8'hAA) begin n_err++; $display("FAIL read_first_new: got 0x%02h want 0xaa", from_data); end
    prog_abort = 1'b1;
    tick();
    prog_abort = 1'b0;
    n_cmp++; if (checksum !== 8'hC0) begin n_err++; $display("FAIL read_first_checksum: got 0x%02h want 0xc0", checksum); end
  endtask

  initial begin
    test_reset();
    test_read_sweep();
    test_full_load();
    test_toggle_valid();
    test_abort();
    test_abort_last();
    test_start_in_load();
    test_reset_during_load();
    test_read_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
